// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-master, one-slave round-robin arbiter for the shared
// boot/program memory bus.
//
// Ports:
//   i_clock, i_reset        clock (rising edge), synchronous active-low reset
//   i_pa_* / o_pa_*         port A (instruction fetch): request, rw, address,
//                           wdata in; rdata, 1-cycle ready out
//   i_pb_* / o_pb_*         port B (data load/store), same as port A
//   o_request, o_rw,        registered slave transaction fields
//   o_address, o_wdata
//   i_rdata, i_ready        slave read data and completion
//   o_timeout               1-cycle pulse alongside the master ready of an
//                           aborted transaction
//
// Parameter TIMEOUT: ACTIVE cycles without i_ready before abort (2..65535).
module bus_arbiter_2 #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        i_clock,
    input  logic        i_reset,

    input  logic        i_pa_request,
    input  logic        i_pa_rw,
    input  logic [31:0] i_pa_address,
    input  logic [31:0] i_pa_wdata,
    output logic [31:0] o_pa_rdata,
    output logic        o_pa_ready,

    input  logic        i_pb_request,
    input  logic        i_pb_rw,
    input  logic [31:0] i_pb_address,
    input  logic [31:0] i_pb_wdata,
    output logic [31:0] o_pb_rdata,
    output logic        o_pb_ready,

    output logic        o_request,
    output logic        o_rw,
    output logic [31:0] o_address,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_ready,
    output logic        o_timeout
);

    localparam int unsigned    CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t          state;
    logic            grant_b;       // 1 = port B owns the current transaction
    logic            last_grant_b;  // 1 = port B was served last
    logic [CW-1:0]   counter;
    logic [31:0]     data_q;
    logic            pick_b;

    // B wins when it is the only requester, or when both request and A was
    // served last. Reset leaves last_grant on B so A wins the first tie.
    always_comb begin
        pick_b = i_pb_request & (~i_pa_request | ~last_grant_b);
    end

    // Both masters see the one data register; each only looks at it while
    // its own ready is high.
    assign o_pa_rdata = data_q;
    assign o_pb_rdata = data_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state        <= ST_IDLE;
            grant_b      <= 1'b0;
            last_grant_b <= 1'b1;
            counter      <= '0;
            data_q       <= '0;
            o_request    <= 1'b0;
            o_rw         <= 1'b0;
            o_address    <= '0;
            o_wdata      <= '0;
            o_pa_ready   <= 1'b0;
            o_pb_ready   <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            // Ready and timeout are single-cycle pulses; they are only set
            // on the ACTIVE -> DONE transition below.
            o_pa_ready <= 1'b0;
            o_pb_ready <= 1'b0;
            o_timeout  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_pa_request || i_pb_request) begin
                        grant_b   <= pick_b;
                        o_rw      <= pick_b ? i_pb_rw      : i_pa_rw;
                        o_address <= pick_b ? i_pb_address : i_pa_address;
                        o_wdata   <= pick_b ? i_pb_wdata   : i_pa_wdata;
                        o_request <= 1'b1;
                        counter   <= '0;
                        state     <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    // Completion outputs are registered here so they are
                    // visible during the DONE cycle itself; i_ready takes
                    // priority over an expiring counter.
                    if (i_ready || (counter == CNT_LAST)) begin
                        data_q     <= i_ready ? i_rdata : '0;
                        o_timeout  <= ~i_ready;
                        o_request  <= 1'b0;
                        o_pa_ready <= ~grant_b;
                        o_pb_ready <= grant_b;
                        state      <= ST_DONE;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                ST_DONE: begin
                    last_grant_b <= grant_b;
                    state        <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2.sv
module tb_bus_arbiter_2;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_pa_request, i_pa_rw;
    logic [31:0] i_pa_address, i_pa_wdata;
    logic [31:0] o_pa_rdata;
    logic        o_pa_ready;
    logic        i_pb_request, i_pb_rw;
    logic [31:0] i_pb_address, i_pb_wdata;
    logic [31:0] o_pb_rdata;
    logic        o_pb_ready;
    logic        o_request, o_rw;
    logic [31:0] o_address, o_wdata;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        o_timeout;

    int tests  = 0;
    int failed = 0;

    bus_arbiter_2 #(.TIMEOUT(4)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_pa_request (i_pa_request),
        .i_pa_rw      (i_pa_rw),
        .i_pa_address (i_pa_address),
        .i_pa_wdata   (i_pa_wdata),
        .o_pa_rdata   (o_pa_rdata),
        .o_pa_ready   (o_pa_ready),
        .i_pb_request (i_pb_request),
        .i_pb_rw      (i_pb_rw),
        .i_pb_address (i_pb_address),
        .i_pb_wdata   (i_pb_wdata),
        .o_pb_rdata   (o_pb_rdata),
        .o_pb_ready   (o_pb_ready),
        .o_request    (o_request),
        .o_rw         (o_rw),
        .o_address    (o_address),
        .o_wdata      (o_wdata),
        .i_rdata      (i_rdata),
        .i_ready      (i_ready),
        .o_timeout    (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    // One transaction: master inputs, slave behaviour, expected results.
    // lag = ACTIVE cycles before the slave raises ready (255 = never).
    // exp_wait = negedges from driving the inputs to seeing o_request.
    // exp_cyc  = cycles o_request stays high.
    typedef struct packed {
        logic        a_req;
        logic        a_rw;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic        b_req;
        logic        b_rw;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        logic [7:0]  lag;
        logic [31:0] sdata;
        logic        drop;
        logic        exp_b;
        logic [7:0]  exp_wait;
        logic [7:0]  exp_cyc;
        logic        exp_to;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  w;
        int  cyc;
        logic got;
        logic done;
        i_pa_request = v.a_req;  i_pa_rw = v.a_rw;
        i_pa_address = v.a_addr; i_pa_wdata = v.a_wdata;
        i_pb_request = v.b_req;  i_pb_rw = v.b_rw;
        i_pb_address = v.b_addr; i_pb_wdata = v.b_wdata;
        i_ready = 1'b0;
        got = 1'b0; w = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge i_clock);
            if (k == 1)
                check($sformatf("v%0d_ready_idle", idx), {30'd0, o_pa_ready, o_pb_ready}, 32'd0);
            if (o_request) begin
                got = 1'b1;
                w = k;
            end
        end
        check($sformatf("v%0d_grant_latency", idx), 32'(w), 32'(v.exp_wait));
        if (!got) return;
        check($sformatf("v%0d_rw", idx), {31'd0, o_rw}, {31'd0, v.exp_b ? v.b_rw : v.a_rw});
        check($sformatf("v%0d_address", idx), o_address, v.exp_b ? v.b_addr : v.a_addr);
        check($sformatf("v%0d_wdata", idx), o_wdata, v.exp_b ? v.b_wdata : v.a_wdata);
        if (v.drop) begin
            if (v.exp_b) i_pb_request = 1'b0;
            else         i_pa_request = 1'b0;
        end
        done = 1'b0; cyc = 0;
        for (int k = 1; k <= 10 && !done; k++) begin
            i_ready = (k == int'(v.lag) + 1);
            i_rdata = v.sdata;
            @(negedge i_clock);
            i_ready = 1'b0;
            if (!o_request) begin
                done = 1'b1;
                cyc = k;
            end
        end
        check($sformatf("v%0d_request_cycles", idx), 32'(cyc), 32'(v.exp_cyc));
        check($sformatf("v%0d_pa_ready", idx), {31'd0, o_pa_ready}, {31'd0, ~v.exp_b});
        check($sformatf("v%0d_pb_ready", idx), {31'd0, o_pb_ready}, {31'd0, v.exp_b});
        check($sformatf("v%0d_timeout", idx), {31'd0, o_timeout}, {31'd0, v.exp_to});
        if (v.chk_rd) begin
            check($sformatf("v%0d_rdata", idx), v.exp_b ? o_pb_rdata : o_pa_rdata, v.exp_rd);
        end
    endtask

    initial begin
        //             a_req a_rw  a_addr         a_wdata         b_req b_rw  b_addr         b_wdata         lag    sdata          drop  exp_b wait  cyc   to    chk   exp_rd
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'hA000_0000, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 8'd1,   32'h0BAD_F00D, 1'b0, 1'b0, 8'd1, 8'd2, 1'b0, 1'b1, 32'h0BAD_F00D};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'hA000_0004, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 8'd1,   32'h1111_1111, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0004, 32'hA000_0004, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 8'd1,   32'h2222_2222, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 1'b1, 32'h2222_2222};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0008, 32'hA000_0008, 1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 8'd1,   32'h3030_3030, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0008, 32'hA000_0008, 1'b1, 1'b0, 32'h0000_0108, 32'hB000_0108, 8'd1,   32'h3333_3333, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 1'b1, 32'h3333_3333};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_000C, 32'hA000_000C, 1'b1, 1'b0, 32'h0000_0108, 32'hB000_0108, 8'd1,   32'h4444_4444, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b1, 32'h4444_4444};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hA000_0010, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'd1,   32'hDEAD_BEEF, 1'b0, 1'b0, 8'd2, 8'd2, 1'b0, 1'b1, 32'hDEAD_BEEF};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'hA000_0020, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'd255, 32'h5555_5555, 1'b0, 1'b0, 8'd2, 8'd4, 1'b1, 1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0030, 32'hB000_0030, 8'd1,   32'h6666_6666, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b1, 32'h6666_6666};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0040, 32'hA000_0040, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'd3,   32'h7777_7777, 1'b0, 1'b0, 8'd2, 8'd4, 1'b0, 1'b1, 32'h7777_7777};
        tbl[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0099, 8'd0,   32'h0101_0101, 1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_0048, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0000_004C, 32'hB000_004C, 8'd2,   32'h0202_0202, 1'b0, 1'b0, 8'd2, 8'd3, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_0050, 32'hA000_0050, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 8'd2,   32'h8888_8888, 1'b1, 1'b0, 8'd2, 8'd3, 1'b0, 1'b1, 32'h8888_8888};
        // Run after a reset that aborts a transaction: the tie goes to A.
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0070, 32'hA000_0070, 1'b1, 1'b0, 32'h0000_0074, 32'hB000_0074, 8'd1,   32'h9999_AAAA, 1'b0, 1'b0, 8'd1, 8'd2, 1'b0, 1'b1, 32'h9999_AAAA};
        tbl[14] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0074, 32'hB000_0074, 8'd1,   32'hBBBB_CCCC, 1'b0, 1'b1, 8'd2, 8'd2, 1'b0, 1'b1, 32'hBBBB_CCCC};

        i_reset = 1'b0;
        i_pa_request = 1'b0; i_pa_rw = 1'b0; i_pa_address = '0; i_pa_wdata = '0;
        i_pb_request = 1'b0; i_pb_rw = 1'b0; i_pb_address = '0; i_pb_wdata = '0;
        i_rdata = '0; i_ready = 1'b0;
        repeat (3) @(negedge i_clock);
        check("reset_request", {31'd0, o_request}, 32'd0);
        check("reset_rw", {31'd0, o_rw}, 32'd0);
        check("reset_address", o_address, 32'd0);
        check("reset_wdata", o_wdata, 32'd0);
        check("reset_rdata", o_pa_rdata | o_pb_rdata, 32'd0);
        check("reset_ready_timeout", {29'd0, o_pa_ready, o_pb_ready, o_timeout}, 32'd0);
        i_reset = 1'b1;

        for (int i = 0; i <= 12; i++) run_vec(i, tbl[i]);

        // Reset in the middle of an ACTIVE transaction.
        i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h0000_0060; i_pa_wdata = '0;
        i_pb_request = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge i_clock);
                seen = o_request;
            end
            check("rst_mid_request_seen", {31'd0, seen}, 32'd1);
        end
        i_reset = 1'b0;
        @(negedge i_clock);
        check("rst_mid_request", {31'd0, o_request}, 32'd0);
        check("rst_mid_address", o_address, 32'd0);
        check("rst_mid_ready_timeout", {29'd0, o_pa_ready, o_pb_ready, o_timeout}, 32'd0);
        @(negedge i_clock);
        check("rst_hold_ready_timeout", {29'd0, o_pa_ready, o_pb_ready, o_timeout}, 32'd0);
        i_reset = 1'b1;

        for (int i = 13; i <= 14; i++) run_vec(i, tbl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
